// File: rtl/kbd_rx_fifo.sv
// kbd_rx_fifo: keyboard receive FIFO with bus-mapped data/status registers and interrupt
module kbd_rx_fifo #(
    parameter int          DEPTH    = 16,
    parameter logic [63:0] KEY_BASE = 64'h0000_0000_0000_3000,
    parameter logic [3:0]  IRQ_ID   = 4'd1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     key_pressed,
    input  logic [7:0]               ascii,
    input  logic [63:0]              bus_address,
    input  logic                     bus_read_enable,
    output logic [63:0]              bus_read_data,
    output logic [3:0]               interrupt_vector,
    input  logic                     interrupt_ack,
    output logic [$clog2(DEPTH):0]   fifo_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [7:0]    push_data;
    logic          key_q, push_req, acc_q, ovf, srv;
    logic          data_sel, stat_sel, start, empty, full, pop, push_ok, drop, srv_n;
    logic [CW-1:0] cnt_n;
    logic [63:0]   status;

    // Edge detection, occupancy arithmetic and the interrupt's next state
    always_comb begin
        data_sel = bus_address == KEY_BASE;
        stat_sel = bus_address == KEY_BASE + 64'd4;
        start    = bus_read_enable && (data_sel || stat_sel) && !acc_q;
        empty    = fifo_count == '0;
        full     = fifo_count == CW'(DEPTH);
        pop      = start && data_sel && !empty;
        push_ok  = push_req && (!full || pop);
        drop     = push_req && full && !pop;
        cnt_n    = fifo_count + CW'(push_ok) - CW'(pop);
        srv_n    = (push_ok || cnt_n == '0) ? 1'b0 : (interrupt_ack && !empty && !srv) ? 1'b1 : srv;
        status   = {{(60 - CW){1'b0}}, fifo_count, 1'b0, ovf, full, !empty};
    end

    // Storage and the captured key code are deliberately left uncleared by reset
    always_ff @(posedge clk) begin
        push_data <= ascii;
        if (push_ok)
            mem[wptr] <= push_data;
    end

    // Control state: pointers, count, sticky overflow, interrupt and read register
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr             <= '0;
            rptr             <= '0;
            fifo_count       <= '0;
            ovf              <= 1'b0;
            srv              <= 1'b0;
            key_q            <= 1'b0;
            push_req         <= 1'b0;
            acc_q            <= 1'b0;
            bus_read_data    <= '0;
            interrupt_vector <= '0;
        end else begin
            key_q            <= key_pressed && ascii != 8'd0;
            push_req         <= key_pressed && ascii != 8'd0 && !key_q;
            acc_q            <= bus_read_enable && (data_sel || stat_sel);
            wptr             <= push_ok ? wptr + AW'(1) : wptr;
            rptr             <= pop ? rptr + AW'(1) : rptr;
            fifo_count       <= cnt_n;
            ovf              <= (start && stat_sel) ? drop : (ovf || drop);
            srv              <= srv_n;
            interrupt_vector <= (cnt_n != '0 && !srv_n) ? IRQ_ID : 4'd0;
            if (start)
                bus_read_data <= data_sel ? (empty ? 64'd0 : {56'd0, mem[rptr]}) : status;
        end
    end
endmodule

// File: tb/tb_kbd_rx_fifo.sv
// tb_kbd_rx_fifo: directed self-checking bench for kbd_rx_fifo
module tb_kbd_rx_fifo;
    localparam logic [63:0] DATA = 64'h3000;
    localparam logic [63:0] STAT = 64'h3004;

    logic        clk = 1'b0;
    logic        reset, key_pressed, bus_read_enable, interrupt_ack;
    logic [7:0]  ascii;
    logic [63:0] bus_address, bus_read_data, v;
    logic [3:0]  interrupt_vector;
    logic [4:0]  fifo_count;
    int          n_checks = 0;
    int          n_fail = 0;

    kbd_rx_fifo dut (
        .clk(clk), .reset(reset), .key_pressed(key_pressed), .ascii(ascii),
        .bus_address(bus_address), .bus_read_enable(bus_read_enable),
        .bus_read_data(bus_read_data), .interrupt_vector(interrupt_vector),
        .interrupt_ack(interrupt_ack), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [7:0] a);
        key_pressed = 1'b1;
        ascii = a;
        tick;
        key_pressed = 1'b0;
        ascii = 8'd0;
        tick;
    endtask

    task automatic rd(input logic [63:0] a, output logic [63:0] r);
        bus_address = a;
        bus_read_enable = 1'b1;
        tick;
        r = bus_read_data;
        bus_read_enable = 1'b0;
        tick;
    endtask

    initial begin
        reset = 1'b1;
        key_pressed = 1'b0;
        ascii = 8'd0;
        bus_address = '0;
        bus_read_enable = 1'b0;
        interrupt_ack = 1'b0;
        tick;
        tick;
        reset = 1'b0;
        check("reset_data", bus_read_data, 64'd0);
        check("reset_irq", {60'd0, interrupt_vector}, 64'd0);
        check("reset_count", {59'd0, fifo_count}, 64'd0);

        // Held key: single push, irq two cycles after the edge
        key_pressed = 1'b1;
        ascii = 8'h61;
        tick;
        check("hold_irq_early", {60'd0, interrupt_vector}, 64'd0);
        tick;
        check("hold_irq", {60'd0, interrupt_vector}, 64'd1);
        check("hold_count1", {59'd0, fifo_count}, 64'd1);
        repeat (98) tick;
        check("hold_count100", {59'd0, fifo_count}, 64'd1);
        key_pressed = 1'b0;
        ascii = 8'd0;
        tick;
        rd(DATA, v);
        check("hold_data", v, 64'h61);
        check("hold_drained", {59'd0, fifo_count}, 64'd0);
        check("hold_irq_clear", {60'd0, interrupt_vector}, 64'd0);

        // Long strobe pops once and keeps the data stable
        press(8'h68);
        press(8'h69);
        bus_address = DATA;
        bus_read_enable = 1'b1;
        tick;
        check("read_h", bus_read_data, 64'h68);
        check("read_h_count", {59'd0, fifo_count}, 64'd1);
        repeat (49) tick;
        check("read_h_stable", bus_read_data, 64'h68);
        check("read_h_count_stable", {59'd0, fifo_count}, 64'd1);
        bus_read_enable = 1'b0;
        tick;
        rd(DATA, v);
        check("read_i", v, 64'h69);
        check("read_i_count", {59'd0, fifo_count}, 64'd0);

        // Acknowledge masks the interrupt until the next push
        press(8'h78);
        check("ack_pre", {60'd0, interrupt_vector}, 64'd1);
        interrupt_ack = 1'b1;
        tick;
        interrupt_ack = 1'b0;
        check("ack_irq", {60'd0, interrupt_vector}, 64'd0);
        check("ack_count", {59'd0, fifo_count}, 64'd1);
        press(8'h79);
        check("ack_repush", {60'd0, interrupt_vector}, 64'd1);
        check("ack_count2", {59'd0, fifo_count}, 64'd2);
        rd(DATA, v);
        check("ack_x", v, 64'h78);
        rd(DATA, v);
        check("ack_y", v, 64'h79);

        // Overfill by two, status read clears the sticky overflow
        for (int i = 0; i < 18; i++) press(8'h41 + 8'(i));
        tick;
        check("full_count", {59'd0, fifo_count}, 64'd16);
        rd(STAT, v);
        check("stat_ovf", v, 64'h107);
        rd(STAT, v);
        check("stat_ovf_clear", v, 64'h103);

        // Push and pop start together while full
        bus_address = DATA;
        bus_read_enable = 1'b1;
        key_pressed = 1'b1;
        ascii = 8'h5A;
        tick;
        check("simul_oldest", bus_read_data, 64'h41);
        bus_read_enable = 1'b0;
        key_pressed = 1'b0;
        ascii = 8'd0;
        tick;
        tick;
        check("simul_count", {59'd0, fifo_count}, 64'd16);
        rd(STAT, v);
        check("simul_stat", v, 64'h103);
        for (int i = 1; i < 16; i++) begin
            rd(DATA, v);
            check("drain", v, 64'h41 + 64'(i));
        end
        rd(DATA, v);
        check("drain_last", v, 64'h5A);
        check("drain_count", {59'd0, fifo_count}, 64'd0);

        // Empty read returns zero without underflow
        rd(DATA, v);
        check("empty_read", v, 64'd0);
        check("empty_count", {59'd0, fifo_count}, 64'd0);

        // Reset in the middle of a strobe and a held key
        press(8'h71);
        bus_address = STAT;
        bus_read_enable = 1'b1;
        tick;
        check("pre_reset_stat", bus_read_data, 64'h11);
        key_pressed = 1'b1;
        ascii = 8'h6B;
        tick;
        tick;
        check("pre_reset_count", {59'd0, fifo_count}, 64'd2);
        reset = 1'b1;
        tick;
        reset = 1'b0;
        check("mid_reset_data", bus_read_data, 64'd0);
        check("mid_reset_irq", {60'd0, interrupt_vector}, 64'd0);
        check("mid_reset_count", {59'd0, fifo_count}, 64'd0);
        tick;
        tick;
        check("post_reset_push", {59'd0, fifo_count}, 64'd1);
        check("post_reset_irq", {60'd0, interrupt_vector}, 64'd1);
        repeat (5) tick;
        check("post_reset_once", {59'd0, fifo_count}, 64'd1);
        key_pressed = 1'b0;
        ascii = 8'd0;
        bus_read_enable = 1'b0;
        tick;
        rd(DATA, v);
        check("post_reset_data", v, 64'h6B);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/kbd_rx_fifo.md
Name: kbd_rx_fifo

Overview:
Keyboard receive buffer between the PS/2 decoder and the system bus read path. It captures each new ASCII keypress into a FIFO and exposes a pop-on-read data register and a status register at fixed bus addresses. It raises an interrupt vector toward the CPU while data is pending and clears it on acknowledge. This replaces the single-byte, overwrite-prone keyboard read and interrupt logic at the top level.

Parameters:
DEPTH, 16, FIFO entries; must be a power of 2, from 2 to 256.
KEY_BASE, 64'h0000_0000_0000_3000, data register address; the status register is at KEY_BASE+4.
IRQ_ID, 4'd1, value driven on interrupt_vector while an interrupt is pending.

Ports:
clk  input  1  system clock, 50 MHz bus domain.
reset  input  1  synchronous, active-high reset.
key_pressed  input  1  level from the PS/2 decoder; high while a key is held.
ascii  input  8  ASCII code from the PS/2 decoder; valid while key_pressed is high.
bus_address  input  64  CPU bus address.
bus_read_enable  input  1  CPU read strobe; may stay high for many clk cycles per access.
bus_read_data  output  64  registered read data.
interrupt_vector  output  4  IRQ_ID when pending, otherwise 0.
interrupt_ack  input  1  CPU acknowledge.
fifo_count  output  log2(DEPTH)+1  current occupancy, for debug LEDs.

Behaviour:
- Reset (synchronous, active-high):
  - Clears the read and write pointers, the count, the overflow flag, the serviced flag, the edge registers and bus_read_data.
  - interrupt_vector reads 0 after reset.
  - FIFO contents are not cleared.
- Push:
  - A push is requested on the rising edge of (key_pressed && ascii != 0). This is detected with a 1-cycle delayed register.
  - The push writes ascii into the FIFO one cycle after the edge is detected. Holding a key produces exactly one push.
  - A push when full with no pop in the same cycle: the data is dropped and the overflow flag is set (sticky).
- Access detection:
  - data_sel = (bus_address == KEY_BASE).
  - stat_sel = (bus_address == KEY_BASE+4).
  - An access starts on the rising edge of (bus_read_enable && (data_sel || stat_sel)). Only the first cycle of a held strobe counts.
- Data read:
  - On access start with data_sel, bus_read_data <= {56'd0, head} on the next clk edge and the read pointer advances (pop).
  - If the FIFO is empty, bus_read_data <= 0 and no pop occurs.
- Status read:
  - On access start with stat_sel, bus_read_data <= {zeros, count, 1'b0, overflow, full, !empty}.
  - Bit layout: bit0 = not-empty, bit1 = full, bit2 = overflow, bit3 = 0, bits[3+W:4] = count.
  - The overflow flag clears in the same cycle (read-to-clear). A simultaneous new overflow keeps the flag set.
- bus_read_data holds its value between accesses and ignores all other addresses.
- Latency: data appears 1 clk after the access starts and stays stable for the rest of the strobe.
- Simultaneous push and pop:
  - Both take effect and the count is unchanged.
  - If full, the pop frees the slot and the push is accepted, with no overflow.
  - If empty, the pop returns 0 and does nothing, and the push proceeds.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Count ranges from 0 to DEPTH and is tracked separately, so full and empty are distinguishable.
- Interrupt:
  - pending = !empty && !serviced; interrupt_vector = pending ? IRQ_ID : 0 (registered).
  - interrupt_ack high while pending sets serviced.
  - serviced clears on any accepted push, or when the FIFO becomes empty.
  - An ack while not pending is ignored.
- Reset during an access or a held key:
  - State is cleared and the edge registers are set to 0.
  - A key still held after reset counts as a new edge and pushes once.
  - A read strobe still high after reset counts as a new access.

Test Plan:
- Push 'a' (8'h61) and hold key_pressed for 100 cycles -> count=1, one entry only; interrupt_vector=1 two cycles after the edge.
- Push 'h','i', then read KEY_BASE with bus_read_enable held for 50 cycles -> bus_read_data=64'h68 one cycle after the strobe rises, count=1; the second read returns 64'h69 and count=0.
- Push DEPTH+2 keys, then read status -> bit0=1, bit1=1, bit2=1, count=DEPTH; a second status read shows bit2=0.
- Assert interrupt_ack while pending -> interrupt_vector=0 next cycle with count unchanged; a new push re-raises it to 1.
- Push edge and data-read start in the same cycle with the FIFO full -> count stays DEPTH, overflow stays 0, and the oldest entry is returned.
- Read KEY_BASE while empty -> bus_read_data=0 and count stays 0; assert reset mid-strobe -> all outputs 0 next cycle.
